std_clock_gate_controller: RTL



---
 rtl/std_clock_gate_controller_pkg.sv | 22 ++
 rtl/std_clock_gate_controller_if.sv | 25 ++
 rtl/std_clock_gate_controller_gate.sv | 31 +++
 rtl/std_clock_gate_controller.sv | 113 +++++++++++
 4 files changed

// File: rtl/std_clock_gate_controller_pkg.sv
// Shared types and helpers for the gated-clock enable sequencer.
// Optional statistics outputs are built when STD_CLOCK_GATE_CONTROLLER_STATS_EN is defined.
package std_clock_gate_controller_pkg;

    typedef enum logic [1:0] {
        STD_CLOCK_GATE_OFF  = 2'd0,
        STD_CLOCK_GATE_WAKE = 2'd1,
        STD_CLOCK_GATE_ON   = 2'd2,
        STD_CLOCK_GATE_IDLE = 2'd3
    } std_clock_gate_state_t;

    localparam int STD_TECHNOLOGY_SIMULATION = 0;
    localparam int STD_TECHNOLOGY_ASIC       = 1;

    // Counter must hold the larger of the two delays minus one; never 0 bits.
    function automatic int cnt_width(input int wake_c, input int idle_c);
        int m;
        m = (wake_c > idle_c) ? wake_c : idle_c;
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/std_clock_gate_controller_if.sv
// Request/status bundle between requesters and the clock gate sequencer.
// Master drives requests, slave (the controller) returns enable and status.
interface std_clock_gate_controller_if #(
    parameter int NUM_REQ = 2
);
    import std_clock_gate_controller_pkg::*;

    logic [NUM_REQ-1:0]    req;
    logic                  busy;
    logic                  force_on;
    logic                  clk_en;
    logic                  ready;
    std_clock_gate_state_t state_out;

    modport master (
        output req, busy, force_on,
        input  clk_en, ready, state_out
    );

    modport slave (
        input  req, busy, force_on,
        output clk_en, ready, state_out
    );

endinterface

// File: rtl/std_clock_gate_controller_gate.sv
// Glitch-free clock gate cell: enable is captured while the clock is low.
// TECHNOLOGY selects a latch model or a falling-edge flop implementation.
module std_clock_gate
    import std_clock_gate_controller_pkg::*;
#(
    parameter int TECHNOLOGY = STD_TECHNOLOGY_SIMULATION
) (
    input  logic clk_in,
    input  logic clk_en,
    output logic clk_out
);

    generate
        if (TECHNOLOGY == STD_TECHNOLOGY_SIMULATION) begin : g_latch
            logic en_lat;
            // Transparent while the clock is low so enable edges never chop a high phase.
            always_latch begin
                if (!clk_in) en_lat = clk_en;
            end
            assign clk_out = clk_in & en_lat;
        end else begin : g_flop
            logic en_q;
            // Falling-edge capture gives the same low-phase timing as the latch.
            always_ff @(negedge clk_in) begin
                en_q <= clk_en;
            end
            assign clk_out = clk_in & en_q;
        end
    endgenerate

endmodule

// File: rtl/std_clock_gate_controller.sv
// Sequences clock enable for a gated domain: wake delay, ready, idle hysteresis.
// Define STD_CLOCK_GATE_CONTROLLER_STATS_EN to add gated_cycles/wake_events counters.
module std_clock_gate_controller
    import std_clock_gate_controller_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 8,
    parameter int TECHNOLOGY  = STD_TECHNOLOGY_SIMULATION
) (
    input  logic                        clk,
    input  logic                        rst,
    std_clock_gate_controller_if.slave  bus,
    output logic                        clk_gated
`ifdef STD_CLOCK_GATE_CONTROLLER_STATS_EN
    ,
    output logic [31:0]                 gated_cycles,
    output logic [15:0]                 wake_events
`endif
);

    localparam int CW = cnt_width(WAKE_CYCLES, IDLE_CYCLES);

    std_clock_gate_state_t state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [NUM_REQ-1:0]    req_v;
    logic                  wake, keep;
    logic                  clk_en_q, ready_q;

    assign req_v = bus.req;
    assign wake  = (|req_v) | bus.force_on;
    assign keep  = wake | bus.busy;

    // Next-state and counter decode; keep always beats idle expiry.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            STD_CLOCK_GATE_OFF: begin
                if (wake) begin
                    if (WAKE_CYCLES > 0) begin
                        state_n = STD_CLOCK_GATE_WAKE;
                        cnt_n   = CW'(WAKE_CYCLES - 1);
                    end else begin
                        state_n = STD_CLOCK_GATE_ON;
                    end
                end
            end
            STD_CLOCK_GATE_WAKE: begin
                if (cnt == '0) state_n = STD_CLOCK_GATE_ON;
                else           cnt_n   = cnt - CW'(1);
            end
            STD_CLOCK_GATE_ON: begin
                if (!keep) begin
                    if (IDLE_CYCLES > 0) begin
                        state_n = STD_CLOCK_GATE_IDLE;
                        cnt_n   = CW'(IDLE_CYCLES - 1);
                    end else begin
                        state_n = STD_CLOCK_GATE_OFF;
                    end
                end
            end
            STD_CLOCK_GATE_IDLE: begin
                if (keep)           state_n = STD_CLOCK_GATE_ON;
                else if (cnt == '0) state_n = STD_CLOCK_GATE_OFF;
                else                cnt_n   = cnt - CW'(1);
            end
            default: state_n = STD_CLOCK_GATE_OFF;
        endcase
    end

    // State, counter and the dedicated enable/ready flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= STD_CLOCK_GATE_OFF;
            cnt      <= '0;
            clk_en_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            clk_en_q <= (state_n != STD_CLOCK_GATE_OFF);
            ready_q  <= (state_n == STD_CLOCK_GATE_ON) ||
                        (state_n == STD_CLOCK_GATE_IDLE);
        end
    end

    assign bus.clk_en    = clk_en_q;
    assign bus.ready     = ready_q;
    assign bus.state_out = state;

    std_clock_gate #(
        .TECHNOLOGY (TECHNOLOGY)
    ) u_gate (
        .clk_in  (clk),
        .clk_en  (clk_en_q),
        .clk_out (clk_gated)
    );

`ifdef STD_CLOCK_GATE_CONTROLLER_STATS_EN
    // Saturating counts of gated-off cycles and wake-ups from OFF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gated_cycles <= '0;
            wake_events  <= '0;
        end else if (state == STD_CLOCK_GATE_OFF) begin
            if (gated_cycles != '1) gated_cycles <= gated_cycles + 32'd1;
            if (wake && (wake_events != '1)) wake_events <= wake_events + 16'd1;
        end
    end
`endif

endmodule
